// File: rtl/am_handler_counter.sv
// am_handler_counter
//   Counts Active Message handler packets per local kernel and raises a level
//   interrupt per kernel once its count reaches a programmable threshold.
//   All kernels share one AXI4-Lite slave with a 16-byte window per kernel:
//     +0x0 COUNT (RO), +0x4 THRESHOLD (RW, byte strobes),
//     +0x8 CTRL (bit0 IRQ_EN, bit1 CLR self-clearing),
//     +0xC STATUS (bit0 PENDING, write-1-to-clear).
//   Optional feature macro: AM_HANDLER_DROP_CNT_EN adds a 32-bit saturating
//   DROP_COUNT at window NUM_KERNELS, offset 0x0 (read-only, any write clears).

module am_handler_counter #(
    parameter int NUM_KERNELS = 16,
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [15:0]            address_offset,
    input  logic [63:0]            axis_handler_tdata,
    input  logic                   axis_handler_tvalid,
    input  logic                   axis_handler_tlast,
    output logic                   axis_handler_tready,
    input  logic                   s_axi_ctrl_bus_AWVALID,
    output logic                   s_axi_ctrl_bus_AWREADY,
    input  logic [ADDR_WIDTH-1:0]  s_axi_ctrl_bus_AWADDR,
    input  logic                   s_axi_ctrl_bus_WVALID,
    output logic                   s_axi_ctrl_bus_WREADY,
    input  logic [DATA_WIDTH-1:0]  s_axi_ctrl_bus_WDATA,
    input  logic [STRB_WIDTH-1:0]  s_axi_ctrl_bus_WSTRB,
    output logic                   s_axi_ctrl_bus_BVALID,
    input  logic                   s_axi_ctrl_bus_BREADY,
    output logic [1:0]             s_axi_ctrl_bus_BRESP,
    input  logic                   s_axi_ctrl_bus_ARVALID,
    output logic                   s_axi_ctrl_bus_ARREADY,
    input  logic [ADDR_WIDTH-1:0]  s_axi_ctrl_bus_ARADDR,
    output logic                   s_axi_ctrl_bus_RVALID,
    input  logic                   s_axi_ctrl_bus_RREADY,
    output logic [DATA_WIDTH-1:0]  s_axi_ctrl_bus_RDATA,
    output logic [1:0]             s_axi_ctrl_bus_RRESP,
    output logic [NUM_KERNELS-1:0] interrupt
);

    localparam int                   WIN_W      = ADDR_WIDTH - 4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [15:0]          NK_16      = 16'(NUM_KERNELS);
    localparam logic [WIN_W-1:0]     NK_WIN     = WIN_W'(NUM_KERNELS);
    localparam logic [1:0]           RESP_OKAY  = 2'b00;
    localparam logic [1:0]           RESP_SLVERR = 2'b10;
    localparam logic [1:0]           REG_COUNT  = 2'd0;
    localparam logic [1:0]           REG_THR    = 2'd1;
    localparam logic [1:0]           REG_CTRL   = 2'd2;
    localparam logic [1:0]           REG_STATUS = 2'd3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } stream_state_e;

    // Read-mux word for one kernel window; CLR always reads back as 0.
    function automatic logic [DATA_WIDTH-1:0] kernel_word(
        input logic [1:0]           reg_sel,
        input logic [CNT_WIDTH-1:0] cnt,
        input logic [CNT_WIDTH-1:0] thr,
        input logic                 en,
        input logic                 pend
    );
        logic [DATA_WIDTH-1:0] w;
        case (reg_sel)
            REG_COUNT:  w = DATA_WIDTH'(cnt);
            REG_THR:    w = DATA_WIDTH'(thr);
            REG_CTRL:   w = {{(DATA_WIDTH-1){1'b0}}, en};
            REG_STATUS: w = {{(DATA_WIDTH-1){1'b0}}, pend};
            default:    w = {DATA_WIDTH{1'b0}};
        endcase
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Stream side
    // ------------------------------------------------------------------
    stream_state_e          state_q, state_d;
    logic                   tready_q;
    logic                   beat_s;
    logic                   hdr_s;
    logic                   in_range_s;
    logic                   drop_s;
    logic [15:0]            kid_s;
    logic [NUM_KERNELS-1:0] inc_s;

    assign beat_s = axis_handler_tvalid & tready_q;

    // Stream FSM state register; tready rises on the first edge after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= 1'b1;
        end
    end

    // Stream FSM next state: multi-beat packets are drained to their tlast beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (beat_s && !axis_handler_tlast) state_d = ST_DRAIN;
                else                               state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                if (beat_s && axis_handler_tlast) state_d = ST_IDLE;
                else                              state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stream FSM outputs: header decode into a one-hot kernel increment.
    always_comb begin
        kid_s = axis_handler_tdata[15:0] - address_offset;
        if (state_q == ST_IDLE) hdr_s = beat_s;
        else                    hdr_s = 1'b0;
        in_range_s = (kid_s < NK_16);
        drop_s     = hdr_s & ~in_range_s;
        for (int i = 0; i < NUM_KERNELS; i++) begin
            inc_s[i] = hdr_s & in_range_s & (kid_s == 16'(i));
        end
    end

    // ------------------------------------------------------------------
    // AXI-Lite write path
    // ------------------------------------------------------------------
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  wr_fire_s;
    logic                  wr_ok_s;
    logic                  drop_clr_s;
    logic [WIN_W-1:0]      wr_win_s;
    logic [1:0]            wr_reg_s;

    assign wr_fire_s = aw_held_q & w_held_q;
    assign wr_win_s  = awaddr_q[ADDR_WIDTH-1:4];
    assign wr_reg_s  = awaddr_q[3:2];

    // Write address decode: which windows answer OKAY and whether DROP_COUNT is hit.
    always_comb begin
`ifdef AM_HANDLER_DROP_CNT_EN
        drop_clr_s = wr_fire_s & (wr_win_s == NK_WIN) & (wr_reg_s == REG_COUNT);
        wr_ok_s    = (wr_win_s < NK_WIN) | ((wr_win_s == NK_WIN) & (wr_reg_s == REG_COUNT));
`else
        drop_clr_s = 1'b0;
        wr_ok_s    = (wr_win_s < NK_WIN);
`endif
    end

    // Write channel handshake: hold AW and W independently, commit when both held.
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        if (wr_fire_s) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (s_axi_ctrl_bus_AWVALID && awready_q) begin
                aw_held_d = 1'b1;
                awaddr_d  = s_axi_ctrl_bus_AWADDR;
            end else begin
                aw_held_d = aw_held_q;
            end
            if (s_axi_ctrl_bus_WVALID && wready_q) begin
                w_held_d = 1'b1;
                wdata_d  = s_axi_ctrl_bus_WDATA;
                wstrb_d  = s_axi_ctrl_bus_WSTRB;
            end else begin
                w_held_d = w_held_q;
            end
        end
        if (bvalid_q) begin
            bvalid_d = ~s_axi_ctrl_bus_BREADY;
        end else begin
            bvalid_d = wr_fire_s;
            if (wr_fire_s) bresp_d = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
            else           bresp_d = bresp_q;
        end
        awready_d = ~aw_held_d & ~bvalid_d;
        wready_d  = ~w_held_d & ~bvalid_d;
    end

    // Write channel registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q   <= {DATA_WIDTH{1'b0}};
            wstrb_q   <= {STRB_WIDTH{1'b0}};
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-kernel register file
    // ------------------------------------------------------------------
    logic [CNT_WIDTH-1:0]   count_q     [NUM_KERNELS];
    logic [CNT_WIDTH-1:0]   count_d     [NUM_KERNELS];
    logic [CNT_WIDTH-1:0]   threshold_q [NUM_KERNELS];
    logic [CNT_WIDTH-1:0]   threshold_d [NUM_KERNELS];
    logic [NUM_KERNELS-1:0] irq_en_q, irq_en_d;
    logic [NUM_KERNELS-1:0] pending_q, pending_d;
    logic [NUM_KERNELS-1:0] interrupt_q;
    logic [NUM_KERNELS-1:0] wr_sel_s, clr_s, w1c_s, hit_s;

    // Next-state for counters, thresholds, enables and pending flags.
    always_comb begin
        for (int i = 0; i < NUM_KERNELS; i++) begin
            wr_sel_s[i] = wr_fire_s & (wr_win_s == WIN_W'(i));
            clr_s[i]    = wr_sel_s[i] & (wr_reg_s == REG_CTRL) & wstrb_q[0] & wdata_q[1];
            w1c_s[i]    = wr_sel_s[i] & (wr_reg_s == REG_STATUS) & wstrb_q[0] & wdata_q[0];

            // IRQ_EN follows bit 0 of a CTRL write with byte 0 enabled.
            if (wr_sel_s[i] && (wr_reg_s == REG_CTRL) && wstrb_q[0]) irq_en_d[i] = wdata_q[0];
            else                                                     irq_en_d[i] = irq_en_q[i];

            // THRESHOLD honours byte strobes bit by bit.
            for (int b = 0; b < CNT_WIDTH; b++) begin
                if (wr_sel_s[i] && (wr_reg_s == REG_THR) && wstrb_q[b/8]) threshold_d[i][b] = wdata_q[b];
                else                                                      threshold_d[i][b] = threshold_q[i][b];
            end

            // A clear coinciding with an increment keeps the increment.
            if (clr_s[i]) begin
                count_d[i] = inc_s[i] ? CNT_ONE : {CNT_WIDTH{1'b0}};
            end else if (inc_s[i] && (count_q[i] != CNT_MAX)) begin
                count_d[i] = count_q[i] + CNT_ONE;
            end else begin
                count_d[i] = count_q[i];
            end

            // The clear wins for one cycle; a still-met threshold re-sets on the next.
            hit_s[i] = (threshold_q[i] != {CNT_WIDTH{1'b0}}) & (count_q[i] >= threshold_q[i]);
            if (w1c_s[i])      pending_d[i] = 1'b0;
            else if (hit_s[i]) pending_d[i] = 1'b1;
            else               pending_d[i] = pending_q[i];
        end
    end

    // Per-kernel register storage and registered interrupt outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_KERNELS; i++) begin
                count_q[i]     <= {CNT_WIDTH{1'b0}};
                threshold_q[i] <= {CNT_WIDTH{1'b0}};
            end
            irq_en_q    <= {NUM_KERNELS{1'b0}};
            pending_q   <= {NUM_KERNELS{1'b0}};
            interrupt_q <= {NUM_KERNELS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_KERNELS; i++) begin
                count_q[i]     <= count_d[i];
                threshold_q[i] <= threshold_d[i];
            end
            irq_en_q    <= irq_en_d;
            pending_q   <= pending_d;
            interrupt_q <= pending_q & irq_en_q;
        end
    end

`ifdef AM_HANDLER_DROP_CNT_EN
    // ------------------------------------------------------------------
    // Dropped-packet counter
    // ------------------------------------------------------------------
    logic [31:0] drop_q, drop_d;

    // DROP_COUNT next state: saturating, cleared by any write, a coincident drop survives.
    always_comb begin
        if (drop_clr_s)                         drop_d = drop_s ? 32'd1 : 32'd0;
        else if (drop_s && (drop_q != 32'hFFFF_FFFF)) drop_d = drop_q + 32'd1;
        else                                    drop_d = drop_q;
    end

    // DROP_COUNT register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) drop_q <= 32'd0;
        else       drop_q <= drop_d;
    end
`endif

    // ------------------------------------------------------------------
    // AXI-Lite read path
    // ------------------------------------------------------------------
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic                  ar_hs_s;
    logic [WIN_W-1:0]      rd_win_s;
    logic [1:0]            rd_reg_s;
    logic [DATA_WIDTH-1:0] rd_data_s;
    logic                  rd_ok_s;

    assign ar_hs_s  = s_axi_ctrl_bus_ARVALID & arready_q;
    assign rd_win_s = s_axi_ctrl_bus_ARADDR[ADDR_WIDTH-1:4];
    assign rd_reg_s = s_axi_ctrl_bus_ARADDR[3:2];

    // Read mux: OR of the selected window; unmatched windows yield 0.
    always_comb begin
        rd_data_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_KERNELS; i++) begin
            rd_data_s = rd_data_s | ({DATA_WIDTH{rd_win_s == WIN_W'(i)}} &
                        kernel_word(rd_reg_s, count_q[i], threshold_q[i], irq_en_q[i], pending_q[i]));
        end
`ifdef AM_HANDLER_DROP_CNT_EN
        rd_data_s = rd_data_s | ({DATA_WIDTH{(rd_win_s == NK_WIN) & (rd_reg_s == REG_COUNT)}} &
                    DATA_WIDTH'(drop_q));
        rd_ok_s   = (rd_win_s < NK_WIN) | ((rd_win_s == NK_WIN) & (rd_reg_s == REG_COUNT));
`else
        rd_ok_s   = (rd_win_s < NK_WIN);
`endif
    end

    // Read channel next state: capture on AR handshake, hold until RREADY.
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (rvalid_q) begin
            rvalid_d = ~s_axi_ctrl_bus_RREADY;
        end else if (ar_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data_s;
            rresp_d  = rd_ok_s ? RESP_OKAY : RESP_SLVERR;
        end else begin
            rvalid_d = 1'b0;
        end
        arready_d = ~rvalid_d;
    end

    // Read channel registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= {DATA_WIDTH{1'b0}};
            rresp_q   <= RESP_OKAY;
        end else begin
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Address bits [1:0], payload upper bits and unused strobe/data bits are don't-care.
    logic unused_s;
    assign unused_s = ^{axis_handler_tdata[63:16], awaddr_q[1:0], s_axi_ctrl_bus_ARADDR[1:0],
                        wdata_q, wstrb_q, drop_s, drop_clr_s};

    assign axis_handler_tready    = tready_q;
    assign s_axi_ctrl_bus_AWREADY = awready_q;
    assign s_axi_ctrl_bus_WREADY  = wready_q;
    assign s_axi_ctrl_bus_BVALID  = bvalid_q;
    assign s_axi_ctrl_bus_BRESP   = bresp_q;
    assign s_axi_ctrl_bus_ARREADY = arready_q;
    assign s_axi_ctrl_bus_RVALID  = rvalid_q;
    assign s_axi_ctrl_bus_RDATA   = rdata_q;
    assign s_axi_ctrl_bus_RRESP   = rresp_q;
    assign interrupt              = interrupt_q;

endmodule

// File: tb/tb_am_handler_counter.sv
// Directed self-checking bench for am_handler_counter
// (NUM_KERNELS=8, CNT_WIDTH=4, address_offset=0x20).

module tb_am_handler_counter;

    localparam int NK = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address_offset;
    logic [63:0] tdata;
    logic        tvalid, tlast, tready;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [11:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [NK-1:0] irq;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    am_handler_counter #(
        .NUM_KERNELS(NK), .ADDR_WIDTH(12), .DATA_WIDTH(32), .STRB_WIDTH(4), .CNT_WIDTH(4)
    ) dut (
        .clock(clock), .reset(reset), .address_offset(address_offset),
        .axis_handler_tdata(tdata), .axis_handler_tvalid(tvalid),
        .axis_handler_tlast(tlast), .axis_handler_tready(tready),
        .s_axi_ctrl_bus_AWVALID(awvalid), .s_axi_ctrl_bus_AWREADY(awready),
        .s_axi_ctrl_bus_AWADDR(awaddr), .s_axi_ctrl_bus_WVALID(wvalid),
        .s_axi_ctrl_bus_WREADY(wready), .s_axi_ctrl_bus_WDATA(wdata),
        .s_axi_ctrl_bus_WSTRB(wstrb), .s_axi_ctrl_bus_BVALID(bvalid),
        .s_axi_ctrl_bus_BREADY(bready), .s_axi_ctrl_bus_BRESP(bresp),
        .s_axi_ctrl_bus_ARVALID(arvalid), .s_axi_ctrl_bus_ARREADY(arready),
        .s_axi_ctrl_bus_ARADDR(araddr), .s_axi_ctrl_bus_RVALID(rvalid),
        .s_axi_ctrl_bus_RREADY(rready), .s_axi_ctrl_bus_RDATA(rdata),
        .s_axi_ctrl_bus_RRESP(rresp), .interrupt(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_pkt(input logic [15:0] id, input int beats);
        int n;
        for (int b = 0; b < beats; b++) begin
            tvalid = 1'b1;
            tdata  = {48'h0000_0000_BEEF, id};
            tlast  = (b == beats - 1);
            n = 0;
            while (!tready && n < 50) begin
                tick();
                n++;
            end
            if (!tready) timeout_fail("stream_tready");
            tick();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done, w_done, aw_now, w_now;
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 50) begin
            aw_now = awvalid & awready;
            w_now  = wvalid & wready;
            tick();
            if (aw_now) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_now)  begin w_done  = 1'b1; wvalid  = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) timeout_fail("write_addr_data");
        n = 0;
        while (!bvalid && n < 50) begin
            tick();
            n++;
        end
        if (!bvalid) timeout_fail("write_bvalid");
        resp = bresp;
        tick();
    endtask

    task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit hs;
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b0;
        hs = 1'b0; n = 0;
        while (!hs && n < 50) begin
            hs = arready;
            tick();
            n++;
        end
        arvalid = 1'b0;
        if (!hs) timeout_fail("read_arready");
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin
            tick();
            n++;
        end
        if (!rvalid) timeout_fail("read_rvalid");
        data = rdata;
        resp = rresp;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [31:0] exp_cnt [NK];

        reset = 1'b1; address_offset = 16'h0020;
        tdata = 64'h0; tvalid = 1'b0; tlast = 1'b0;
        awvalid = 1'b0; awaddr = 12'h0; wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; bready = 1'b0;
        arvalid = 1'b0; araddr = 12'h0; rready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_tready", 32'(tready), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_awready", 32'(awready), 32'h0);
        check("rst_arready", 32'(arready), 32'h0);
        check("rst_bvalid", 32'(bvalid), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        reset = 1'b0;
        tick();
        check("post_rst_tready", 32'(tready), 32'h1);
        check("post_rst_awready", 32'(awready), 32'h1);

        // Three single-beat packets to ID 0x22 -> kernel 2
        for (int i = 0; i < 3; i++) send_pkt(16'h0022, 1);
        for (int k = 0; k < NK; k++) exp_cnt[k] = 32'h0;
        exp_cnt[2] = 32'h3;
        for (int k = 0; k < NK; k++) begin
            axi_read(12'(k * 16), d, r);
            check($sformatf("count_k%0d", k), d, exp_cnt[k]);
        end
        check("count_resp", 32'(r), 32'h0);

        // Threshold / interrupt on kernel 1
        axi_write(12'h014, 32'h0000_0002, 4'hF, r);
        axi_write(12'h018, 32'h0000_0001, 4'hF, r);
        axi_read(12'h014, d, r);
        check("thr1_rd", d, 32'h2);
        axi_read(12'h018, d, r);
        check("ctrl1_rd", d, 32'h1);
        send_pkt(16'h0021, 4);
        check("irq_after_pkt1", 32'(irq), 32'h0);
        tvalid = 1'b1; tdata = {48'h0, 16'h0021}; tlast = 1'b0;
        tick();
        check("irq_accept_p0", 32'(irq[1]), 32'h0);
        tick();
        check("irq_accept_p1", 32'(irq[1]), 32'h0);
        tick();
        check("irq_accept_p2", 32'(irq[1]), 32'h1);
        tlast = 1'b1;
        tick();
        tvalid = 1'b0; tlast = 1'b0;
        axi_read(12'h010, d, r);
        check("count1_2", d, 32'h2);

        // W1C while threshold still met: a one-cycle dip, then PENDING re-sets
        axi_write(12'h01C, 32'h0000_0001, 4'hF, r);
        check("irq_w1c_dip", 32'(irq[1]), 32'h0);
        axi_read(12'h01C, d, r);
        check("status1_reset", d, 32'h1);
        check("irq_reasserted", 32'(irq[1]), 32'h1);

        // CLR then W1C -> interrupt drops
        axi_write(12'h018, 32'h0000_0003, 4'hF, r);
        axi_write(12'h01C, 32'h0000_0001, 4'hF, r);
        check("irq_cleared", 32'(irq), 32'h0);
        axi_read(12'h010, d, r);
        check("count1_clr", d, 32'h0);
        axi_read(12'h018, d, r);
        check("ctrl1_clr_reads0", d, 32'h1);
        axi_read(12'h01C, d, r);
        check("status1_clear", d, 32'h0);

        // Saturation at 15 for a 4-bit counter
        for (int i = 0; i < 17; i++) send_pkt(16'h0020, 1);
        axi_read(12'h000, d, r);
        check("count0_sat", d, 32'hF);
        axi_read(12'h00C, d, r);
        check("status0_thr0", d, 32'h0);

        // CLR of kernel 3 coinciding with an increment to kernel 3
        send_pkt(16'h0023, 1);
        send_pkt(16'h0023, 1);
        awvalid = 1'b1; awaddr = 12'h038; wvalid = 1'b1; wdata = 32'h2; wstrb = 4'h1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tvalid = 1'b1; tdata = {48'h0, 16'h0023}; tlast = 1'b1;
        tick();
        tvalid = 1'b0; tlast = 1'b0;
        check("clr_inc_bvalid", 32'(bvalid), 32'h1);
        tick();
        axi_read(12'h030, d, r);
        check("count3_clr_inc", d, 32'h1);

        // Out-of-range packet ID 0x28 is dropped
        send_pkt(16'h0028, 1);
        axi_read(12'h000, d, r); check("drop_k0", d, 32'hF);
        axi_read(12'h010, d, r); check("drop_k1", d, 32'h0);
        axi_read(12'h020, d, r); check("drop_k2", d, 32'h3);
        axi_read(12'h030, d, r); check("drop_k3", d, 32'h1);
        axi_read(12'h080, d, r);
`ifdef AM_HANDLER_DROP_CNT_EN
        check("dropcnt_data", d, 32'h1);
        check("dropcnt_resp", 32'(r), 32'h0);
        axi_write(12'h080, 32'h0, 4'h0, r);
        check("dropcnt_wr_resp", 32'(r), 32'h0);
        axi_read(12'h080, d, r);
        check("dropcnt_cleared", d, 32'h0);
`else
        check("win_nk_data", d, 32'h0);
        check("win_nk_resp", 32'(r), 32'h2);
`endif
        axi_write(12'h094, 32'h1, 4'hF, r);
        check("oor_wr_resp", 32'(r), 32'h2);
        axi_write(12'h020, 32'h7, 4'hF, r);
        check("count_wr_resp", 32'(r), 32'h0);
        axi_read(12'h020, d, r);
        check("count_wr_ignored", d, 32'h3);

        // AW three cycles ahead of W, BREADY held low for five cycles
        bready = 1'b0;
        awvalid = 1'b1; awaddr = 12'h054;
        tick();
        awvalid = 1'b0;
        check("aw_held_awready", 32'(awready), 32'h0);
        tick(); tick();
        wvalid = 1'b1; wdata = 32'h9; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        tick();
        check("aw_w_bvalid", 32'(bvalid), 32'h1);
        check("aw_w_bresp", 32'(bresp), 32'h0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bhold_bvalid_%0d", i), 32'(bvalid), 32'h1);
            check($sformatf("bhold_ready_%0d", i), 32'({awready, wready}), 32'h0);
            tick();
        end
        bready = 1'b1;
        tick();
        check("bvalid_released", 32'(bvalid), 32'h0);
        axi_read(12'h054, d, r);
        check("thr5_rd", d, 32'h9);
        axi_write(12'h054, 32'h6, 4'hE, r);
        axi_read(12'h054, d, r);
        check("thr5_strb_masked", d, 32'h9);

        // Reset pulse mid-packet: FSM back to IDLE, next beat is a header
        tvalid = 1'b1; tdata = {48'h0, 16'h0024}; tlast = 1'b0;
        tick();
        tvalid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst_tready", 32'(tready), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        tick();
        reset = 1'b0;
        tick();
        send_pkt(16'h0024, 1);
        axi_read(12'h040, d, r);
        check("count4_after_rst", d, 32'h1);
        axi_read(12'h020, d, r);
        check("count2_after_rst", d, 32'h0);
        axi_read(12'h054, d, r);
        check("thr5_after_rst", d, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/am_handler_counter.md
Name: am_handler_counter

Overview:
- Parametrised successor to the GAScore handler block: counts Active Message handler packets per kernel and raises per-kernel interrupts.
- Kernel count is a parameter (NUM_KERNELS), not a fixed 16.
- All kernels share one AXI4-Lite control slave, with a 16-byte register window per kernel, instead of one bus per kernel.
- Sits between the GAScore block design's axis_handler stream and the kernels' interrupt lines.

Parameters:
NUM_KERNELS, 16, number of kernel channels (1..64)
ADDR_WIDTH, 12, AXI-Lite address width; must be >= clog2(NUM_KERNELS+1)+4
DATA_WIDTH, 32, AXI-Lite data width (fixed 32)
STRB_WIDTH, DATA_WIDTH/8, write strobe width
CNT_WIDTH, 16, per-kernel counter width (<= 32)

Ports:
clock  in  1  single clock domain
reset  in  1  asynchronous, active-high reset
address_offset  in  16  global ID of local kernel 0
axis_handler_tdata  in  64  handler stream data
axis_handler_tvalid  in  1  stream valid
axis_handler_tlast  in  1  end of handler packet
axis_handler_tready  out  1  stream ready
s_axi_ctrl_bus_AWVALID/AWREADY/AWADDR[ADDR_WIDTH]/WVALID/WREADY/WDATA[32]/WSTRB[4]  AXI-Lite write address and data channels
s_axi_ctrl_bus_BVALID/BREADY/BRESP[2]  write response channel
s_axi_ctrl_bus_ARVALID/ARREADY/ARADDR/RVALID/RREADY/RDATA[32]/RRESP[2]  read channels
interrupt  out  NUM_KERNELS  level interrupt per kernel

Behaviour:
- Reset (async, reset=1):
  - All counters, thresholds, CTRL and STATUS registers go to 0.
  - interrupt=0, axis_handler_tready=0, all AXI VALID/READY outputs=0, stream FSM=IDLE.
  - Reset asserted mid-packet or mid-transaction aborts it; no partial update survives.
- Stream FSM, states IDLE, DRAIN:
  - tready=1 in both states from the first cycle after reset deassert.
  - IDLE, beat accepted: k = tdata[15:0] - address_offset (16-bit wrap).
    - If k < NUM_KERNELS, COUNT[k] increments one cycle later, saturating at 2^CNT_WIDTH-1.
    - Otherwise the packet is dropped.
    - If tlast=0, go to DRAIN; a single-beat packet stays in IDLE.
  - DRAIN: discard beats until a tlast beat is accepted, then return to IDLE.
- Register window for kernel k at byte base k*16; reg = addr[3:2]:
  - 0x0 COUNT: read-only; writes ignored with OKAY response.
  - 0x4 THRESHOLD: read/write, low CNT_WIDTH bits.
  - 0x8 CTRL: bit0 IRQ_EN (read/write); bit1 CLR, write-1 clears COUNT and reads 0.
  - 0xC STATUS: bit0 PENDING, write-1-to-clear.
- WSTRB: honoured per byte on THRESHOLD; ignored elsewhere, where bit-0 writes need WSTRB[0]=1.
- Interrupt generation:
  - PENDING[k] sets on the cycle COUNT[k] >= THRESHOLD[k] while THRESHOLD[k] != 0; it sets regardless of IRQ_EN.
  - interrupt[k] = PENDING[k] & IRQ_EN[k], registered, so it follows PENDING by 1 cycle.
  - W1C on PENDING while the condition still holds: PENDING re-sets on the next cycle.
- Simultaneous events:
  - CLR in the same cycle as a stream increment to the same kernel gives COUNT=1; the increment is never lost.
  - Read of COUNT in the same cycle as an increment returns the pre-increment value.
- AXI-Lite write path:
  - AW and W are accepted independently; each READY goes low once its beat is held.
  - Register update occurs the cycle both are held.
  - BVALID is asserted the next cycle and held until BREADY.
  - No new AW/W is accepted while BVALID=1.
- AXI-Lite read path:
  - ARREADY=1 when idle; RVALID asserts 1 cycle after the AR handshake and holds until RREADY.
  - ARREADY=0 while RVALID=1.
- Window index >= NUM_KERNELS: RESP=2'b10 (SLVERR), RDATA=0, no state change.
- Unused upper RDATA bits read 0.

Optional Feature:
- Macro: AM_HANDLER_DROP_CNT_EN.
- Defined:
  - Window index NUM_KERNELS, offset 0x0, is DROP_COUNT (32-bit, saturating, read-only).
  - It counts packets dropped for an out-of-range k.
  - Any write to it clears it and returns OKAY.
- Undefined: no DROP_COUNT register and no counter logic; that address returns SLVERR like any other out-of-range window.

Test Plan:
- address_offset=0x20; send 3 single-beat packets with tdata[15:0]=0x22 -> COUNT[2] reads 3, all other COUNT registers read 0.
- THRESHOLD[1]=2, IRQ_EN[1]=1; send 2 packets to ID 0x21 (4-beat packets) -> interrupt[1] rises 2 cycles after the 2nd first-beat accept; W1C STATUS[1] with THRESHOLD still met -> PENDING re-sets; CLR then W1C -> interrupt[1]=0.
- CNT_WIDTH=4; send 17 packets to kernel 0 -> COUNT[0]=15 (saturated).
- CLR of COUNT[3] coinciding with a stream increment to kernel 3 -> COUNT[3]=1.
- Packet with ID 0x20+NUM_KERNELS -> no counter changes; read of window NUM_KERNELS -> DROP_COUNT=1 with the macro, SLVERR/0 without it.
- AW presented 3 cycles before W, BREADY held low 5 cycles -> a single register update; BVALID stays high until BREADY; reset pulse mid-packet -> FSM returns to IDLE and the next beat is treated as a header.
